pndes: RTL and testbench
========================

PNDES -- requirements
Module: pndes

Interface
REQ-001 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-002 rst_ni  input  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion is sampled on clk_i.
REQ-003 dat_i  input  1  serial packet stream, one bit per clock, MSB first.
REQ-004 len_i  input  5  number of data bits in the incoming packet (0..31); sampled once per packet, on the header-match cycle.
REQ-005 dat_o  output  32  received data, MSB-aligned (first data bit in bit 31); unused low bits are 0.
REQ-006 len_o  output  5  length of the packet reported by dat_o.
REQ-007 vld_o  output  1  one-cycle pulse: dat_o/len_o hold a packet with a correct footer.
REQ-008 err_o  output  1  one-cycle pulse: footer mismatch; packet discarded.

Function
REQ-009 Packet format: header 4'b1101, then len data bits, then footer 4'b0101, then at least 1 gap bit before the next header.
REQ-010 FSM states: HUNT, DATA, FOOT; reset state is HUNT.
REQ-011 HUNT: 4-bit window win <= {win[2:0],dat_i} every cycle; a match exists when {win[2:0],dat_i}==4'b1101.
REQ-012 HUNT on match: latch len_i into rlen, clear dat_r; go to DATA with cnt=len_i-1 if len_i!=0, else go to FOOT with cnt=3.
REQ-013 DATA: per cycle dat_r[31-idx] <= dat_i; idx increments from 0; cnt decrements; when cnt==0 go to FOOT with cnt=3.
REQ-014 FOOT: shift dat_i into fwin; cnt decrements; when cnt==0 compare {fwin[2:0],dat_i} with 4'b0101, then go to HUNT.
REQ-015 HUNT re-entry clears win to 4'b0000; a header is never detected from bits of the previous packet.
REQ-016 Footer match: the next cycle vld_o=1, dat_o=dat_r, len_o=rlen; otherwise err_o=1 and dat_o/len_o keep their previous values.
REQ-017 Latency: vld_o/err_o assert exactly 1 cycle after the last footer bit is sampled; vld_o and err_o are never high together.
REQ-018 dat_o/len_o change only on a vld_o cycle and stay stable between pulses.
REQ-019 Back-to-back: a header starting on the cycle after the last footer bit (zero gap) is not detected. With 1 gap bit, the header is detected.
REQ-020 len=0: DATA is skipped; a good footer yields vld_o with dat_o=0, len_o=0.
REQ-021 len=31: dat_o[0]=0; the 32nd bit position is never written.
REQ-022 No stall or backpressure: the stream is consumed at line rate; vld_o is not held.

Reset
REQ-023 Reset values: state=HUNT; win, fwin, cnt, idx, rlen, dat_r=0; dat_o=32'h0, len_o=5'h0, vld_o=0, err_o=0.
REQ-024 Reset mid-packet aborts the packet with no vld_o/err_o pulse; hunting restarts from an empty window after deassertion.

Structure
REQ-025 Shared package pn_pkg: HEADER=4'b1101, FOOTER=4'b0101, and the HUNT/DATA/FOOT state encoding; the serializer and pndes both use it.
REQ-026 One sub-module, pn_win4: a 4-bit shift window with clear and compare-to-constant, instantiated twice (header match, footer match).
REQ-027 Outputs are registered; no combinational path from dat_i to any output.

Verification
REQ-028 Stream 1101 + 8 bits 10110011 + 0101, len_i=8 -> vld_o one cycle after the last footer bit; dat_o=32'hB300_0000, len_o=8.
REQ-029 Same packet with footer 0111 -> err_o pulse only; dat_o/len_o unchanged from the previous good packet.
REQ-030 len_i=0, stream 1101 0101 -> vld_o; dat_o=0, len_o=0. len_i=31 with all-ones data -> dat_o=32'hFFFF_FFFE.
REQ-031 Drive the packet serializer output directly, 50 random packets -> every dat_o/len_o matches the generator word and length, in order, with no err_o.
REQ-032 Noise 0110_1001 then a valid packet -> no pulses during the noise; vld_o for the packet with correct data.
REQ-033 Assert rst_ni low for 1 cycle in mid-DATA -> no pulse; the next complete packet decodes correctly.

Source files
------------

// File: rtl/pn_pkg.sv
// pn_pkg: framing constants and FSM encoding shared by the
// packet deserializer and the packet serializer.
package pn_pkg;

  localparam logic [3:0] HEADER = 4'b1101;
  localparam logic [3:0] FOOTER = 4'b0101;

  localparam int unsigned DAT_W = 32;
  localparam int unsigned LEN_W = 5;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    DATA = 2'd1,
    FOOT = 2'd2
  } pn_state_e;

endpackage

// File: rtl/pn_win4.sv
// pn_win4: 4-bit serial shift window with synchronous clear and
// a compare of the would-be next window against a fixed pattern.
module pn_win4
  import pn_pkg::*;
#(
  parameter logic [3:0] PAT = 4'b0000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en,
  input  logic clr,
  input  logic bit_i,
  output logic hit
);

  logic [3:0] win;

  assign hit = ({win[2:0], bit_i} == PAT);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win <= 4'b0000;
    end else if (clr) begin
      win <= 4'b0000;
    end else if (en) begin
      win <= {win[2:0], bit_i};
    end
  end

endmodule

// File: rtl/pndes.sv
// pndes: serial packet deserializer (header, len data bits,
// footer), reporting MSB-aligned data with vld/err pulses.
module pndes
  import pn_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               dat_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic [DAT_W-1:0]   dat_o,
  output logic [LEN_W-1:0]   len_o,
  output logic               vld_o,
  output logic               err_o
);

  pn_state_e          state;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   idx;
  logic [LEN_W-1:0]   rlen;
  logic [DAT_W-1:0]   dat_r;
  logic               gap_r;

  logic h_hit;
  logic f_hit;
  logic hdr;
  logic last_foot;

  assign hdr       = (state == HUNT) && !gap_r && h_hit;
  assign last_foot = (state == FOOT) && (cnt == '0);

  // The first HUNT cycle after a packet is held in clear, so a
  // header needs at least one gap bit to be seen.
  pn_win4 #(
    .PAT   (HEADER)
  ) u_hwin (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en    (state == HUNT),
    .clr   (last_foot || gap_r),
    .bit_i (dat_i),
    .hit   (h_hit)
  );

  pn_win4 #(
    .PAT   (FOOTER)
  ) u_fwin (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en    (state == FOOT),
    .clr   (hdr),
    .bit_i (dat_i),
    .hit   (f_hit)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= HUNT;
      cnt   <= '0;
      idx   <= '0;
      rlen  <= '0;
      dat_r <= '0;
      gap_r <= 1'b0;
      dat_o <= '0;
      len_o <= '0;
      vld_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      vld_o <= 1'b0;
      err_o <= 1'b0;
      gap_r <= 1'b0;
      unique case (state)
        HUNT: begin
          if (hdr) begin
            rlen  <= len_i;
            dat_r <= '0;
            idx   <= '0;
            if (len_i != '0) begin
              state <= DATA;
              cnt   <= len_i - 5'd1;
            end else begin
              state <= FOOT;
              cnt   <= 5'd3;
            end
          end
        end
        DATA: begin
          dat_r[5'd31 - idx] <= dat_i;
          idx <= idx + 5'd1;
          if (cnt == '0) begin
            state <= FOOT;
            cnt   <= 5'd3;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        FOOT: begin
          if (cnt == '0) begin
            state <= HUNT;
            gap_r <= 1'b1;
            if (f_hit) begin
              vld_o <= 1'b1;
              dat_o <= dat_r;
              len_o <= rlen;
            end else begin
              err_o <= 1'b1;
            end
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_pndes.sv
// tb_pndes: randomized self-checking bench for pndes with a
// bench-side serializer and a word/length reference model.
module tb_pndes;
  import pn_pkg::*;

  logic        clk_i;
  logic        rst_ni;
  logic        dat_i;
  logic [4:0]  len_i;
  logic [31:0] dat_o;
  logic [4:0]  len_o;
  logic        vld_o;
  logic        err_o;

  int checks;
  int errors;
  int nv;
  int ne;
  int nboth;

  pndes dut (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .dat_i (dat_i),
    .len_i (len_i),
    .dat_o (dat_o),
    .len_o (len_o),
    .vld_o (vld_o),
    .err_o (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (vld_o) nv <= nv + 1;
    if (err_o) ne <= ne + 1;
    if (vld_o && err_o) nboth <= nboth + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model_word(input logic [4:0] len,
                                             input logic [31:0] data);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < int'(len); i++) m[31-i] = 1'b1;
    return data & m;
  endfunction

  task automatic send_bit(input logic b);
    dat_i = b;
    @(posedge clk_i);
    #1;
  endtask

  // Serializer: header, len data bits MSB first, footer, gap zeros.
  task automatic send_pkt(input logic [4:0] len, input logic [31:0] data,
                          input logic [3:0] foot, input int gap,
                          output logic [31:0] od, output logic [4:0] ol,
                          output logic ov, output logic oe);
    logic [3:0] h;
    h = HEADER;
    for (int i = 3; i >= 0; i--) begin
      len_i = (i == 0) ? len : ~len;
      send_bit(h[i]);
    end
    len_i = 5'($urandom);
    for (int i = 0; i < int'(len); i++) send_bit(data[31-i]);
    for (int i = 3; i >= 0; i--) send_bit(foot[i]);
    od = dat_o;
    ol = len_o;
    ov = vld_o;
    oe = err_o;
    for (int i = 0; i < gap; i++) send_bit(1'b0);
  endtask

  task automatic chk_good(input string nm, input logic [31:0] od,
                          input logic [4:0] ol, input logic ov, input logic oe,
                          input logic [31:0] ed, input logic [4:0] el);
    checks += 4;
    if (ov !== 1'b1) begin
      errors++;
      $display("FAIL %s vld: got %b want 1", nm, ov);
    end
    if (oe !== 1'b0) begin
      errors++;
      $display("FAIL %s err: got %b want 0", nm, oe);
    end
    if (od !== ed) begin
      errors++;
      $display("FAIL %s dat: got %h want %h", nm, od, ed);
    end
    if (ol !== el) begin
      errors++;
      $display("FAIL %s len: got %0d want %0d", nm, ol, el);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    dat_i = 1'b0;
    len_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    checks += 4;
    if (dat_o !== 32'h0) begin
      errors++;
      $display("FAIL reset dat_o: got %h want 0", dat_o);
    end
    if (len_o !== 5'h0) begin
      errors++;
      $display("FAIL reset len_o: got %0d want 0", len_o);
    end
    if (vld_o !== 1'b0) begin
      errors++;
      $display("FAIL reset vld_o: got %b want 0", vld_o);
    end
    if (err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset err_o: got %b want 0", err_o);
    end
    rst_ni = 1'b1;
    send_bit(1'b0);
    send_bit(1'b0);
  endtask

  task automatic test_basic();
    logic [31:0] od;
    logic [4:0] ol;
    logic ov, oe;
    int v0, e0;
    v0 = nv;
    e0 = ne;
    send_pkt(5'd8, 32'hB300_0000, FOOTER, 1, od, ol, ov, oe);
    chk_good("basic", od, ol, ov, oe, 32'hB300_0000, 5'd8);
    checks++;
    if (nv - v0 != 1 || ne != e0) begin
      errors++;
      $display("FAIL basic pulses: vld %0d err %0d want 1 0", nv - v0, ne - e0);
    end
  endtask

  task automatic test_bad_footer();
    logic [31:0] od;
    logic [4:0] ol;
    logic ov, oe;
    send_pkt(5'd8, 32'hB300_0000, 4'b0111, 1, od, ol, ov, oe);
    checks += 4;
    if (ov !== 1'b0) begin
      errors++;
      $display("FAIL badfoot vld: got %b want 0", ov);
    end
    if (oe !== 1'b1) begin
      errors++;
      $display("FAIL badfoot err: got %b want 1", oe);
    end
    if (od !== 32'hB300_0000) begin
      errors++;
      $display("FAIL badfoot dat: got %h want b3000000", od);
    end
    if (ol !== 5'd8) begin
      errors++;
      $display("FAIL badfoot len: got %0d want 8", ol);
    end
  endtask

  task automatic test_len_edges();
    logic [31:0] od;
    logic [4:0] ol;
    logic ov, oe;
    send_pkt(5'd0, 32'hFFFF_FFFF, FOOTER, 2, od, ol, ov, oe);
    chk_good("len0", od, ol, ov, oe, 32'h0, 5'd0);
    send_pkt(5'd31, 32'hFFFF_FFFF, FOOTER, 1, od, ol, ov, oe);
    chk_good("len31", od, ol, ov, oe, 32'hFFFF_FFFE, 5'd31);
  endtask

  task automatic test_random();
    logic [31:0] od, data;
    logic [4:0] ol, len;
    logic ov, oe;
    int e0;
    e0 = ne;
    for (int k = 0; k < 50; k++) begin
      len = 5'($urandom);
      data = $urandom;
      send_pkt(len, data, FOOTER, int'($urandom_range(1, 3)),
               od, ol, ov, oe);
      chk_good($sformatf("rand%0d", k), od, ol, ov, oe,
               model_word(len, data), len);
    end
    checks++;
    if (ne != e0) begin
      errors++;
      $display("FAIL random errpulses: got %0d want 0", ne - e0);
    end
  endtask

  task automatic test_noise();
    logic [31:0] od;
    logic [4:0] ol;
    logic ov, oe;
    logic [7:0] noise;
    int v0, e0;
    noise = 8'b0110_1001;
    v0 = nv;
    e0 = ne;
    len_i = 5'd31;
    for (int i = 7; i >= 0; i--) send_bit(noise[i]);
    send_bit(1'b0);
    checks++;
    if (nv != v0 || ne != e0) begin
      errors++;
      $display("FAIL noise pulses: vld %0d err %0d want 0 0", nv - v0, ne - e0);
    end
    // 1101 inside the noise opens a 31-bit frame whose footer is idle zeros.
    repeat (40) send_bit(1'b0);
    checks++;
    if (nv != v0 || ne != e0 + 1) begin
      errors++;
      $display("FAIL noise frame: vld %0d err %0d want 0 1", nv - v0, ne - e0);
    end
    send_pkt(5'd12, 32'h5A70_0000, FOOTER, 1, od, ol, ov, oe);
    chk_good("noise_pkt", od, ol, ov, oe, 32'h5A70_0000, 5'd12);
  endtask

  task automatic test_reset_mid();
    logic [31:0] od;
    logic [4:0] ol;
    logic ov, oe;
    logic [3:0] h;
    int v0, e0;
    h = HEADER;
    for (int i = 3; i >= 0; i--) begin
      len_i = 5'd16;
      send_bit(h[i]);
    end
    repeat (5) send_bit(1'b1);
    rst_ni = 1'b0;
    #1;
    checks++;
    if (dat_o !== 32'h0 || vld_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL midrst outputs: dat %h vld %b err %b want 0 0 0",
               dat_o, vld_o, err_o);
    end
    v0 = nv;
    e0 = ne;
    send_bit(1'b1);
    rst_ni = 1'b1;
    repeat (14) send_bit(1'b1);
    repeat (30) send_bit(1'b0);
    checks++;
    if (nv != v0 || ne != e0) begin
      errors++;
      $display("FAIL midrst pulses: vld %0d err %0d want 0 0", nv - v0, ne - e0);
    end
    send_pkt(5'd20, 32'hC0FF_E000, FOOTER, 1, od, ol, ov, oe);
    chk_good("midrst_pkt", od, ol, ov, oe, 32'hC0FF_E000, 5'd20);
  endtask

  task automatic test_back_to_back();
    logic [31:0] od;
    logic [4:0] ol;
    logic ov, oe;
    int v0;
    v0 = nv;
    send_pkt(5'd6, 32'hA400_0000, FOOTER, 0, od, ol, ov, oe);
    chk_good("b2b0_a", od, ol, ov, oe, 32'hA400_0000, 5'd6);
    send_pkt(5'd8, 32'h0, FOOTER, 2, od, ol, ov, oe);
    checks += 2;
    if (ov !== 1'b0 || oe !== 1'b0) begin
      errors++;
      $display("FAIL b2b0_b pulse: vld %b err %b want 0 0", ov, oe);
    end
    if (nv - v0 != 1) begin
      errors++;
      $display("FAIL b2b0 count: got %0d want 1", nv - v0);
    end
    send_pkt(5'd6, 32'h7C00_0000, FOOTER, 1, od, ol, ov, oe);
    chk_good("b2b1_a", od, ol, ov, oe, 32'h7C00_0000, 5'd6);
    send_pkt(5'd9, 32'h9A80_0000, FOOTER, 1, od, ol, ov, oe);
    chk_good("b2b1_b", od, ol, ov, oe, 32'h9A80_0000, 5'd9);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nv = 0;
    ne = 0;
    nboth = 0;
    test_reset();
    test_basic();
    test_bad_footer();
    test_len_edges();
    test_random();
    test_noise();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (nboth != 0) begin
      errors++;
      $display("FAIL overlap: vld and err high together %0d times", nboth);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
